// File: rtl/linebuf_window_ctrl_if.sv
// rtl/linebuf_window_ctrl_if.sv - pixel-in / column-out stream bundle for linebuf_window_ctrl
// master drives the pixel stream and accepts columns; slave is the window controller.
interface linebuf_window_ctrl_if #(
    parameter int W      = 256,
    parameter int AWIDTH = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [W-1:0]      s_data;
    logic              m_valid;
    logic              m_ready;
    logic [W-1:0]      m_top;
    logic [W-1:0]      m_mid;
    logic [W-1:0]      m_bot;
    logic [AWIDTH-1:0] m_col;
    logic [AWIDTH-1:0] m_row;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_top, m_mid, m_bot, m_col, m_row
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_top, m_mid, m_bot, m_col, m_row
    );
endinterface

// File: rtl/linebuf_window_ctrl.sv
// rtl/linebuf_window_ctrl.sv - two-BRAM line buffer sequencer producing 3-row columns for 3x3 windows
// lb0 holds row y-1, lb1 holds row y-2; each pixel costs one read cycle and one write cycle.
module linebuf_window_ctrl #(
    parameter int DWIDTH   = 8,
    parameter int P_CH     = 32,
    parameter int MEM_SIZE = 512,
    parameter int AWIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [AWIDTH-1:0]      cfg_width_i,
    input  logic [AWIDTH-1:0]      cfg_height_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cfg_err_o,
    linebuf_window_ctrl_if.slave   px,
    output logic [AWIDTH-1:0]      lb0_addr_o,
    output logic [AWIDTH-1:0]      lb1_addr_o,
    output logic [DWIDTH*P_CH-1:0] lb0_d_o,
    output logic [DWIDTH*P_CH-1:0] lb1_d_o,
    input  logic [DWIDTH*P_CH-1:0] lb0_q_i,
    input  logic [DWIDTH*P_CH-1:0] lb1_q_i,
    output logic                   lb0_ce_o,
    output logic                   lb0_we_o,
    output logic                   lb1_ce_o,
    output logic                   lb1_we_o
);
    localparam int W = DWIDTH * P_CH;
    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [AWIDTH-1:0] width_q;
    logic [AWIDTH-1:0] height_q;
    logic [AWIDTH-1:0] col_q;
    logic [AWIDTH-1:0] row_q;
    logic [AWIDTH-1:0] col_d;
    logic [AWIDTH-1:0] row_d;
    logic [W-1:0]      pix_q;
    logic              busy_q;
    logic              done_q;
    logic              cfg_err_q;
    logic              s_ready_q;
    logic              m_valid_q;
    logic [W-1:0]      m_top_q;
    logic [W-1:0]      m_mid_q;
    logic [W-1:0]      m_bot_q;
    logic [AWIDTH-1:0] m_col_q;
    logic [AWIDTH-1:0] m_row_q;

    logic cfg_ok;
    logic row_end;
    logic last_px;
    logic rd_en;
    logic wr_en;

    always_comb begin
        cfg_ok  = (cfg_width_i != '0) && (32'(cfg_width_i) <= 32'(MEM_SIZE)) && (cfg_height_i != '0);
        row_end = (col_q == width_q - ONE);
        last_px = row_end && (row_q == height_q - ONE);
        col_d   = row_end ? '0 : col_q + ONE;
        row_d   = row_end ? row_q + ONE : row_q;
        rd_en   = (state_q == S_RD) && px.s_valid;
        wr_en   = (state_q == S_WR);
    end

    // The read issued on the accepting RD cycle returns in WR, where both
    // lines are rewritten in place: lb0 takes the new pixel, lb1 takes old lb0.
    assign lb0_ce_o   = rd_en || wr_en;
    assign lb1_ce_o   = rd_en || wr_en;
    assign lb0_we_o   = wr_en;
    assign lb1_we_o   = wr_en;
    assign lb0_addr_o = col_q;
    assign lb1_addr_o = col_q;
    assign lb0_d_o    = wr_en ? pix_q : '0;
    assign lb1_d_o    = wr_en ? lb0_q_i : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pix_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_top_q   <= '0;
            m_mid_q   <= '0;
            m_bot_q   <= '0;
            m_col_q   <= '0;
            m_row_q   <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            width_q   <= cfg_width_i;
                            height_q  <= cfg_height_i;
                            col_q     <= '0;
                            row_q     <= '0;
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= S_RD;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (px.s_valid) begin
                        pix_q     <= px.s_data;
                        s_ready_q <= 1'b0;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    // Lines not yet written this frame hold stale data: mask them.
                    m_bot_q   <= pix_q;
                    m_mid_q   <= (row_q != '0) ? lb0_q_i : '0;
                    m_top_q   <= (row_q > ONE) ? lb1_q_i : '0;
                    m_col_q   <= col_q;
                    m_row_q   <= row_q;
                    m_valid_q <= 1'b1;
                    state_q   <= S_OUT;
                end
                S_OUT: begin
                    if (px.m_ready) begin
                        m_valid_q <= 1'b0;
                        col_q     <= col_d;
                        row_q     <= row_d;
                        if (last_px) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cfg_err_o  = cfg_err_q;
    assign px.s_ready = s_ready_q;
    assign px.m_valid = m_valid_q;
    assign px.m_top   = m_top_q;
    assign px.m_mid   = m_mid_q;
    assign px.m_bot   = m_bot_q;
    assign px.m_col   = m_col_q;
    assign px.m_row   = m_row_q;
endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// tb/tb_linebuf_window_ctrl.sv - randomized and directed bench for linebuf_window_ctrl
// Expected columns come from the accepted-pixel history of the frame, indexed by raster position.
module tb_linebuf_window_ctrl;
    localparam int DWIDTH   = 8;
    localparam int P_CH     = 4;
    localparam int W        = DWIDTH * P_CH;
    localparam int MEM_SIZE = 16;
    localparam int AWIDTH   = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AWIDTH-1:0] cfg_width = '0;
    logic [AWIDTH-1:0] cfg_height = '0;
    logic              busy, done, cfg_err;
    logic [AWIDTH-1:0] lb0_addr, lb1_addr;
    logic [W-1:0]      lb0_d, lb1_d;
    logic [W-1:0]      lb0_q = '0;
    logic [W-1:0]      lb1_q = '0;
    logic              lb0_ce, lb0_we, lb1_ce, lb1_we;

    linebuf_window_ctrl_if #(.W(W), .AWIDTH(AWIDTH)) ifc ();

    linebuf_window_ctrl #(
        .DWIDTH(DWIDTH), .P_CH(P_CH), .MEM_SIZE(MEM_SIZE), .AWIDTH(AWIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
        .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err), .px(ifc.slave),
        .lb0_addr_o(lb0_addr), .lb1_addr_o(lb1_addr), .lb0_d_o(lb0_d), .lb1_d_o(lb1_d),
        .lb0_q_i(lb0_q), .lb1_q_i(lb1_q),
        .lb0_ce_o(lb0_ce), .lb0_we_o(lb0_we), .lb1_ce_o(lb1_ce), .lb1_we_o(lb1_we)
    );

    always #5 clk = ~clk;

    // External single-port BRAMs, 1-cycle registered read, preloaded with garbage.
    logic [W-1:0] mem0 [MEM_SIZE];
    logic [W-1:0] mem1 [MEM_SIZE];
    always @(posedge clk) begin
        if (lb0_ce) begin
            if (lb0_we) mem0[int'(lb0_addr) % MEM_SIZE] <= lb0_d;
            else        lb0_q <= mem0[int'(lb0_addr) % MEM_SIZE];
        end
        if (lb1_ce) begin
            if (lb1_we) mem1[int'(lb1_addr) % MEM_SIZE] <= lb1_d;
            else        lb1_q <= mem1[int'(lb1_addr) % MEM_SIZE];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int           fw = 1, fh = 1, n_in = 0, out_idx = 0, cyc = 0;
    int           first_s_cyc = 0, done_cyc = 0;
    bit           frame_on = 0, done_pend = 0, frame_fin = 0, full_mode = 0;
    int           hold_idx = -1, hold_done = 0, hold_cnt = 0;
    int           lat_due[$];
    logic [W-1:0] src [256];
    logic [W-1:0] cap [256];
    logic [W-1:0] log_top [256];
    logic [W-1:0] log_mid [256];
    logic [W-1:0] log_bot [256];
    int           k, r, c;
    logic [W-1:0] et, em, eb;
    bit           lb_ok;

    always @(negedge clk) begin
        if (!rst) begin
            chk(busy == frame_on, "busy", busy, frame_on);
            chk(done == done_pend, "done", done, done_pend);
            if (done) begin
                frame_fin = 1;
                done_cyc  = cyc;
            end
            done_pend = 0;
            chk(!(ifc.s_ready && (ifc.m_valid || !frame_on)), "s_ready_state", ifc.s_ready, 0);
            lb_ok = (lb0_ce == lb1_ce) && (lb0_we == lb1_we) && (lb0_addr == lb1_addr) &&
                    !(lb0_we && !lb0_ce) && !(lb0_ce && (ifc.m_valid || !frame_on)) &&
                    !(lb0_ce && int'(lb0_addr) >= fw);
            chk(lb_ok, "lb_ctrl", {lb0_ce, lb0_we, lb1_ce, lb1_we}, 0);
            if (lb0_ce && !lb0_we) begin
                chk(ifc.s_valid && ifc.s_ready, "rd_without_accept", ifc.s_ready, 1);
                chk(int'(lb0_addr) == n_in % fw, "rd_addr", lb0_addr, n_in % fw);
            end
            if (lb0_we && n_in > 0) begin
                chk(int'(lb0_addr) == (n_in - 1) % fw, "wr_addr", lb0_addr, (n_in - 1) % fw);
                chk(lb0_d == cap[n_in - 1], "wr_data", lb0_d, cap[n_in - 1]);
            end
            if (ifc.s_valid && ifc.s_ready) begin
                cap[n_in] = ifc.s_data;
                if (n_in == 0) first_s_cyc = cyc;
                lat_due.push_back(cyc + 2);
                n_in++;
            end
            if (lat_due.size() > 0 && lat_due[0] == cyc) begin
                void'(lat_due.pop_front());
                chk(ifc.m_valid == 1'b1, "latency", ifc.m_valid, 1);
            end
            if (ifc.m_valid) begin
                if (out_idx >= n_in) begin
                    chk(0, "out_ahead", out_idx, n_in);
                end else begin
                    k  = out_idx;
                    r  = k / fw;
                    c  = k % fw;
                    eb = cap[k];
                    em = (r >= 1) ? cap[k - fw] : '0;
                    et = (r >= 2) ? cap[k - 2 * fw] : '0;
                    chk(ifc.m_bot == eb, "m_bot", ifc.m_bot, eb);
                    chk(ifc.m_mid == em, "m_mid", ifc.m_mid, em);
                    chk(ifc.m_top == et, "m_top", ifc.m_top, et);
                    chk(int'(ifc.m_col) == c, "m_col", ifc.m_col, c);
                    chk(int'(ifc.m_row) == r, "m_row", ifc.m_row, r);
                end
                if (ifc.m_ready) begin
                    log_top[out_idx % 256] = ifc.m_top;
                    log_mid[out_idx % 256] = ifc.m_mid;
                    log_bot[out_idx % 256] = ifc.m_bot;
                    out_idx++;
                    if (out_idx == fw * fh) begin
                        done_pend = 1;
                        frame_on  = 0;
                    end
                end else if (out_idx == hold_idx) begin
                    hold_cnt++;
                end
            end
            cyc++;
        end
    end

    // Stimulus driver: updates inputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        ifc.s_valid = frame_on && (n_in < fw * fh) && (full_mode || $urandom_range(0, 2) != 0);
        ifc.s_data  = src[n_in % 256];
        if (hold_idx >= 0 && ifc.m_valid && out_idx == hold_idx && hold_done < 5) begin
            ifc.m_ready = 1'b0;
            hold_done++;
        end else begin
            ifc.m_ready = full_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_reset(input bit check);
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        frame_on = 0;
        done_pend = 0;
        hold_idx = -1;
        lat_due.delete();
        @(posedge clk);
        @(negedge clk);
        if (check) begin
            chk(busy == 0 && done == 0 && cfg_err == 0, "rst_status", {busy, done, cfg_err}, 0);
            chk(ifc.s_ready == 0 && ifc.m_valid == 0, "rst_handshake", {ifc.s_ready, ifc.m_valid}, 0);
            chk({lb0_ce, lb0_we, lb1_ce, lb1_we} == 4'b0 && lb0_addr == 0 && lb1_addr == 0,
                "rst_lb", {lb0_ce, lb0_we, lb0_addr}, 0);
            chk(ifc.m_top == 0 && ifc.m_mid == 0 && ifc.m_bot == 0 && ifc.m_col == 0 && ifc.m_row == 0,
                "rst_mdata", ifc.m_bot, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input bit full, input bit rnd, input int base,
                             input int hold);
        for (int i = 0; i < 256; i++) src[i] = rnd ? W'($urandom) : W'(base + i);
        fw = w;
        fh = h;
        n_in = 0;
        out_idx = 0;
        frame_fin = 0;
        full_mode = full;
        hold_idx = hold;
        hold_done = 0;
        hold_cnt = 0;
        lat_due.delete();
        @(posedge clk);
        #1;
        cfg_width = AWIDTH'(w);
        cfg_height = AWIDTH'(h);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        frame_on = 1;
    endtask

    task automatic wait_frame(input int limit);
        int n;
        n = 0;
        while (!frame_fin && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk(frame_fin, "frame_timeout", n, limit);
    endtask

    task automatic bad_start(input int w, input int h);
        @(posedge clk);
        #1;
        cfg_width = AWIDTH'(w);
        cfg_height = AWIDTH'(h);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk(cfg_err == 1'b1, "cfg_err_pulse", cfg_err, 1);
        chk(busy == 1'b0, "cfg_err_busy", busy, 0);
        @(negedge clk);
        chk(cfg_err == 1'b0, "cfg_err_clear", cfg_err, 0);
    endtask

    task automatic check_first_frame(input string tag);
        chk(out_idx == 12, {tag, "_count"}, out_idx, 12);
        chk(log_top[10] == 3 && log_mid[10] == 7 && log_bot[10] == 11, {tag, "_px22"},
            {log_top[10][15:0], log_mid[10][15:0], log_bot[10][15:0]}, 48'h0003_0007_000b);
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem0[i] = W'($urandom);
            mem1[i] = W'($urandom);
        end
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        ifc.m_ready = 1'b1;
        do_reset(1);

        // 4x3 ramp, full throughput; start pulses mid-frame must be ignored
        run_frame(4, 3, 1, 0, 1, -1);
        repeat (5) begin
            @(posedge clk);
            #1;
            cfg_width = 2;
            start = 1'b1;
        end
        #1 start = 1'b0;
        wait_frame(500);
        check_first_frame("s1");
        chk(log_top[1] == 0 && log_mid[1] == 0 && log_bot[1] == 2, "px10",
            {log_top[1][15:0], log_mid[1][15:0], log_bot[1][15:0]}, 48'h0000_0000_0002);
        chk(log_top[5] == 0 && log_mid[5] == 2 && log_bot[5] == 6, "px11",
            {log_top[5][15:0], log_mid[5][15:0], log_bot[5][15:0]}, 48'h0000_0002_0006);
        chk(done_cyc - first_s_cyc == 36, "throughput", done_cyc - first_s_cyc, 36);

        // downstream stall at px(0,1)
        run_frame(4, 3, 1, 0, 1, 4);
        wait_frame(500);
        chk(hold_cnt == 5, "stall_cycles", hold_cnt, 5);

        // illegal configurations, then the widest legal one
        bad_start(0, 3);
        bad_start(MEM_SIZE + 1, 3);
        bad_start(4, 0);
        run_frame(MEM_SIZE, 2, 0, 1, 0, -1);
        wait_frame(2000);

        // single-column frame
        run_frame(1, 4, 1, 0, 5, -1);
        wait_frame(500);
        chk(log_top[3] == 6 && log_mid[3] == 7 && log_bot[3] == 8, "w1_last",
            {log_top[3][15:0], log_mid[3][15:0], log_bot[3][15:0]}, 48'h0006_0007_0008);

        // reset while a pixel is in WR, then a clean repeat of the first frame
        run_frame(4, 3, 0, 1, 0, -1);
        for (int n = 0; n < 500 && n_in < 6; n++) @(negedge clk);
        chk(n_in == 6, "reach_px5", n_in, 6);
        do_reset(1);
        run_frame(4, 3, 1, 0, 1, -1);
        wait_frame(500);
        check_first_frame("s6");

        // randomized frames with throttled handshakes
        for (int f = 0; f < 10; f++) begin
            run_frame($urandom_range(1, MEM_SIZE), $urandom_range(1, 5), 0, 1, 0, -1);
            wait_frame(3000);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
